// File: rtl/ysyx_220053_alu_issue.sv
// Decode-and-issue stage feeding the EX ALU: RV64I ALU-subset decode plus a 2-entry skid buffer.
// Optional RV64 word ops (OP-IMM-32 / OP-32) are enabled by defining YSYX_220053_RV64W_EN.
module ysyx_220053_alu_issue #(
   parameter int XLEN = 64,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ILEN-1:0] in_inst,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [3:0]      out_aluop,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic            out_asel,
   output logic            out_bsel,
   output logic            out_wen,
   output logic            out_word,
   output logic            out_illegal
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [3:0]      aluop;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic            asel;
      logic            bsel;
      logic            wen;
      logic            word;
      logic            illegal;
   } uop_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
`ifdef YSYX_220053_RV64W_EN
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
`endif

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SLL   = 4'b0001;
   localparam logic [3:0] ALU_SRL   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_SRA   = 4'b1101;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   state_t state, next_state;
   uop_t   head, skid, dec;
   logic   in_ready_q;
   logic   accept, drain;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i, imm_u;
   logic            shamt_ok;
   logic            legal;
   logic [3:0]      aluop;
   logic            asel, bsel, word;
   logic [XLEN-1:0] imm;

   assign opcode   = in_inst[6:0];
   assign funct3   = in_inst[14:12];
   assign funct7   = in_inst[31:25];
   assign imm_i    = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign imm_u    = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
   // Shift immediates only allow the logical or arithmetic pattern in the upper bits.
   assign shamt_ok = (in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000);

`ifdef YSYX_220053_RV64W_EN
   logic shamt_w_ok;
   assign shamt_w_ok = shamt_ok && !in_inst[25];
`endif

   always_comb begin
      legal = 1'b0;
      aluop = ALU_ADD;
      asel  = 1'b0;
      bsel  = 1'b0;
      word  = 1'b0;
      imm   = '0;
      case (opcode)
         OPC_OP_IMM: begin
            bsel = 1'b1;
            imm  = imm_i;
            case (funct3)
               3'b001: begin
                  legal = shamt_ok;
                  aluop = ALU_SLL;
               end
               3'b101: begin
                  legal = shamt_ok;
                  aluop = in_inst[30] ? ALU_SRA : ALU_SRL;
               end
               default: begin
                  legal = 1'b1;
                  aluop = {1'b0, funct3};
               end
            endcase
         end
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               legal = 1'b1;
               aluop = {1'b0, funct3};
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               legal = 1'b1;
               aluop = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               legal = 1'b1;
               aluop = ALU_SRA;
            end
         end
         OPC_LUI: begin
            legal = 1'b1;
            aluop = ALU_PASSB;
            bsel  = 1'b1;
            imm   = imm_u;
         end
         OPC_AUIPC: begin
            legal = 1'b1;
            asel  = 1'b1;
            bsel  = 1'b1;
            imm   = imm_u;
         end
`ifdef YSYX_220053_RV64W_EN
         OPC_OP_IMM32: begin
            bsel = 1'b1;
            word = 1'b1;
            imm  = imm_i;
            case (funct3)
               3'b000: begin
                  legal = 1'b1;
                  aluop = ALU_ADD;
               end
               3'b001: begin
                  legal = shamt_w_ok;
                  aluop = ALU_SLL;
               end
               3'b101: begin
                  legal = shamt_w_ok;
                  aluop = in_inst[30] ? ALU_SRA : ALU_SRL;
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP32: begin
            word = 1'b1;
            if (funct7 == 7'b0000000 &&
                (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) begin
               legal = 1'b1;
               aluop = {1'b0, funct3};
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               legal = 1'b1;
               aluop = ALU_SUB;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               legal = 1'b1;
               aluop = ALU_SRA;
            end
         end
`endif
         default: legal = 1'b0;
      endcase
      // Illegal instructions leave EX with a harmless, non-writing add.
      if (!legal) begin
         aluop = ALU_ADD;
         asel  = 1'b0;
         bsel  = 1'b0;
         word  = 1'b0;
         imm   = '0;
      end
   end

   always_comb begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.aluop   = aluop;
      dec.rs1     = in_inst[19:15];
      dec.rs2     = in_inst[24:20];
      dec.rd      = in_inst[11:7];
      dec.imm     = imm;
      dec.asel    = asel;
      dec.bsel    = bsel;
      dec.wen     = legal && (in_inst[11:7] != 5'd0);
      dec.word    = word;
      dec.illegal = !legal;
   end

   assign out_valid = (state != EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid && in_ready_q && !flush;
   assign drain     = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= next_state;
         in_ready_q <= (next_state != TWO);
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         EMPTY: if (accept) next_state = ONE;
         ONE: begin
            if (accept && !drain) next_state = TWO;
            else if (drain && !accept) next_state = EMPTY;
         end
         TWO: if (drain) next_state = ONE;
         default: next_state = EMPTY;
      endcase
      if (flush) next_state = EMPTY;
   end

   // Head drives the outputs; skid catches the one extra entry accepted while EX stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         skid <= '0;
      end else if (!flush) begin
         case (state)
            EMPTY: if (accept) head <= dec;
            ONE: begin
               if (accept && drain) head <= dec;
               else if (accept) skid <= dec;
            end
            TWO: if (drain) head <= skid;
            default: ;
         endcase
      end
   end

   assign out_pc      = head.pc;
   assign out_aluop   = head.aluop;
   assign out_rs1     = head.rs1;
   assign out_rs2     = head.rs2;
   assign out_rd      = head.rd;
   assign out_imm     = head.imm;
   assign out_asel    = head.asel;
   assign out_bsel    = head.bsel;
   assign out_wen     = head.wen;
   assign out_word    = head.word;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_ysyx_220053_alu_issue.sv
// Bench for ysyx_220053_alu_issue: directed steps plus random traffic against a queue-based model.
module tb_ysyx_220053_alu_issue;

   typedef struct {
      logic [63:0] pc;
      logic [3:0]  aluop;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic        imm_care;
      logic        asel;
      logic        bsel;
      logic        wen;
      logic        word;
      logic        illegal;
   } exp_t;

   logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_inst;
   logic [63:0] in_pc, out_pc, out_imm;
   logic [3:0]  out_aluop;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic        out_asel, out_bsel, out_wen, out_word, out_illegal;

   int   total = 0;
   int   bad = 0;
   exp_t mq[$];
   logic acc;

   ysyx_220053_alu_issue #(.XLEN(64), .ILEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_aluop(out_aluop), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_imm(out_imm), .out_asel(out_asel), .out_bsel(out_bsel), .out_wen(out_wen),
      .out_word(out_word), .out_illegal(out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode written as a mnemonic table over the documented instruction classes.
   function automatic exp_t ref_decode(input logic [31:0] inst, input logic [63:0] pc);
      exp_t e;
      logic ok;
      logic [3:0] tab [8];
      logic [2:0] f3;
      logic [6:0] f7;
      logic [5:0] top6;
      tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
      f3 = inst[14:12];
      f7 = inst[31:25];
      top6 = inst[31:26];
      e.pc = pc;
      e.rs1 = inst[19:15];
      e.rs2 = inst[24:20];
      e.rd = inst[11:7];
      e.aluop = 4'h0;
      e.imm = 64'h0;
      e.imm_care = 1'b0;
      e.asel = 1'b0;
      e.bsel = 1'b0;
      e.word = 1'b0;
      ok = 1'b0;
      case (inst[6:0])
         7'h13: begin
            ok = 1'b1;
            e.bsel = 1'b1;
            e.imm = {{52{inst[31]}}, inst[31:20]};
            e.imm_care = 1'b1;
            e.aluop = tab[f3];
            if (f3 == 3'd1 || f3 == 3'd5) ok = (top6 == 6'h00) || (top6 == 6'h10);
            if (f3 == 3'd5 && inst[30]) e.aluop = 4'hD;
         end
         7'h33: begin
            if (f7 == 7'h00) begin ok = 1'b1; e.aluop = tab[f3]; end
            if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.aluop = 4'h8; end
            if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.aluop = 4'hD; end
         end
         7'h37: begin
            ok = 1'b1; e.aluop = 4'hF; e.bsel = 1'b1; e.imm_care = 1'b1;
            e.imm = {{32{inst[31]}}, inst[31:12], 12'h000};
         end
         7'h17: begin
            ok = 1'b1; e.asel = 1'b1; e.bsel = 1'b1; e.imm_care = 1'b1;
            e.imm = {{32{inst[31]}}, inst[31:12], 12'h000};
         end
`ifdef YSYX_220053_RV64W_EN
         7'h1B: begin
            e.bsel = 1'b1; e.word = 1'b1; e.imm_care = 1'b1;
            e.imm = {{52{inst[31]}}, inst[31:20]};
            if (f3 == 3'd0) begin ok = 1'b1; e.aluop = 4'h0; end
            if (f3 == 3'd1 || f3 == 3'd5) begin
               ok = ((top6 == 6'h00) || (top6 == 6'h10)) && !inst[25];
               e.aluop = (f3 == 3'd1) ? 4'h1 : (inst[30] ? 4'hD : 4'h5);
            end
         end
         7'h3B: begin
            e.word = 1'b1;
            if (f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) begin ok = 1'b1; e.aluop = tab[f3]; end
            if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.aluop = 4'h8; end
            if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.aluop = 4'hD; end
         end
`endif
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         e.aluop = 4'h0; e.asel = 1'b0; e.bsel = 1'b0; e.word = 1'b0; e.imm_care = 1'b0;
      end
      e.illegal = !ok;
      e.wen = ok && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [31:0] r, s;
      logic [5:0] top6;
      logic [2:0] f3;
      logic [6:0] f7;
      r = $urandom;
      s = $urandom;
      f3 = r[14:12];
      top6 = s[5:0];
      if (top6 == 6'h10) top6 = 6'h11;
      if (s[7:6] == 2'b00) top6 = 6'h00;
      if (s[7:6] == 2'b01 && f3 == 3'd5) top6 = 6'h10;
      f7 = s[8] ? 7'h00 : (s[9] ? 7'h20 : s[16:10]);
      case (s[19:17])
         3'd0, 3'd1: return (f3 == 3'd1 || f3 == 3'd5) ? {top6, r[25:15], f3, r[11:7], 7'h13}
                                                       : {r[31:15], f3, r[11:7], 7'h13};
         3'd2, 3'd3: return {f7, r[24:15], f3, r[11:7], 7'h33};
         3'd4:       return {r[31:7], 7'h37};
         3'd5:       return {r[31:7], 7'h17};
         3'd6:       return s[20] ? {f7, r[24:15], f3, r[11:7], 7'h3B}
                                  : {top6, r[25:15], f3, r[11:7], 7'h1B};
         default:    return r;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      checkOutput("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      checkOutput("in_ready", 64'(in_ready), 64'(mq.size() < 2));
      if (mq.size() > 0) begin
         checkOutput("pc", out_pc, mq[0].pc);
         checkOutput("aluop", 64'(out_aluop), 64'(mq[0].aluop));
         checkOutput("rs1", 64'(out_rs1), 64'(mq[0].rs1));
         checkOutput("rs2", 64'(out_rs2), 64'(mq[0].rs2));
         checkOutput("rd", 64'(out_rd), 64'(mq[0].rd));
         checkOutput("asel", 64'(out_asel), 64'(mq[0].asel));
         checkOutput("bsel", 64'(out_bsel), 64'(mq[0].bsel));
         checkOutput("wen", 64'(out_wen), 64'(mq[0].wen));
         checkOutput("word", 64'(out_word), 64'(mq[0].word));
         checkOutput("illegal", 64'(out_illegal), 64'(mq[0].illegal));
         if (mq[0].imm_care) checkOutput("imm", out_imm, mq[0].imm);
      end
   endtask

   // One clock cycle: drive inputs, advance the model with the same handshake rules, then check.
   task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                                input logic ordy, input logic fl, output logic accepted);
      logic drn;
      in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
      accepted = v && (mq.size() < 2) && !fl;
      drn = (mq.size() > 0) && ordy;
      @(posedge clk);
      #1;
      if (fl) mq.delete();
      else begin
         if (drn) void'(mq.pop_front());
         if (accepted) mq.push_back(ref_decode(inst, pc));
      end
      check_model();
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_inst = 32'h0; in_pc = 64'h0;
      #12;
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("rst_pc", out_pc, 64'd0);
      checkOutput("rst_imm", out_imm, 64'd0);
      checkOutput("rst_aluop", 64'(out_aluop), 64'd0);
      checkOutput("rst_rd", 64'(out_rd), 64'd0);
      checkOutput("rst_illegal", 64'(out_illegal), 64'd0);
      #1 rst_n = 1'b1;

      // addi x5,x0,-1
      applyStimulus(1'b1, 32'hFFF00293, 64'h1000, 1'b1, 1'b0, acc);
      checkOutput("addi_valid", 64'(out_valid), 64'd1);
      checkOutput("addi_aluop", 64'(out_aluop), 64'h0);
      checkOutput("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      checkOutput("addi_rd", 64'(out_rd), 64'd5);
      checkOutput("addi_bsel", 64'(out_bsel), 64'd1);
      checkOutput("addi_wen", 64'(out_wen), 64'd1);

      // Back-to-back sub, sra, sltu, and.
      applyStimulus(1'b1, {7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33}, 64'h1004, 1'b1, 1'b0, acc);
      checkOutput("sub_aluop", 64'(out_aluop), 64'h8);
      applyStimulus(1'b1, {7'h20, 5'd3, 5'd2, 3'd5, 5'd1, 7'h33}, 64'h1008, 1'b1, 1'b0, acc);
      checkOutput("sra_aluop", 64'(out_aluop), 64'hD);
      applyStimulus(1'b1, {7'h00, 5'd3, 5'd2, 3'd3, 5'd1, 7'h33}, 64'h100C, 1'b1, 1'b0, acc);
      checkOutput("sltu_aluop", 64'(out_aluop), 64'h3);
      applyStimulus(1'b1, {7'h00, 5'd3, 5'd2, 3'd7, 5'd1, 7'h33}, 64'h1010, 1'b1, 1'b0, acc);
      checkOutput("and_aluop", 64'(out_aluop), 64'h7);
      checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

      // Stall: three offers, the third waits for in_ready.
      applyStimulus(1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0, acc);
      checkOutput("two_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0, acc);
      checkOutput("stall_head_pc", out_pc, 64'h2000);
      applyStimulus(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0, acc);
      checkOutput("drain1_pc", out_pc, 64'h2004);
      applyStimulus(1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0, acc);
      checkOutput("drain2_pc", out_pc, 64'h2008);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
      checkOutput("drained_valid", 64'(out_valid), 64'd0);

      // lui / auipc
      applyStimulus(1'b1, 32'h800000B7, 64'h3000, 1'b1, 1'b0, acc);
      checkOutput("lui_aluop", 64'(out_aluop), 64'hF);
      checkOutput("lui_imm", out_imm, 64'hFFFF_FFFF_8000_0000);
      applyStimulus(1'b1, 32'h00001117, 64'h8000_0000, 1'b1, 1'b0, acc);
      checkOutput("auipc_asel", 64'(out_asel), 64'd1);
      checkOutput("auipc_imm", out_imm, 64'h1000);
      checkOutput("auipc_pc", out_pc, 64'h8000_0000);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

      // Flush from TWO with an incoming instruction.
      applyStimulus(1'b1, 32'h00400213, 64'h4000, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00500293, 64'h4004, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00600313, 64'h4008, 1'b0, 1'b1, acc);
      checkOutput("flush_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);
      applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

      // addw x3,x1,x2 and an all-ones word.
      applyStimulus(1'b1, 32'h002081BB, 64'h5000, 1'b1, 1'b0, acc);
`ifdef YSYX_220053_RV64W_EN
      checkOutput("addw_aluop", 64'(out_aluop), 64'h0);
      checkOutput("addw_word", 64'(out_word), 64'd1);
      checkOutput("addw_illegal", 64'(out_illegal), 64'd0);
`else
      checkOutput("addw_illegal", 64'(out_illegal), 64'd1);
      checkOutput("addw_wen", 64'(out_wen), 64'd0);
      checkOutput("addw_word", 64'(out_word), 64'd0);
`endif
      applyStimulus(1'b1, 32'hFFFFFFFF, 64'h5004, 1'b1, 1'b0, acc);
      checkOutput("ones_illegal", 64'(out_illegal), 64'd1);
      checkOutput("ones_wen", 64'(out_wen), 64'd0);

      // Asynchronous reset while the buffer holds two entries.
      applyStimulus(1'b1, 32'h00700393, 64'h6000, 1'b0, 1'b0, acc);
      applyStimulus(1'b1, 32'h00800413, 64'h6004, 1'b0, 1'b0, acc);
      #2 rst_n = 1'b0;
      #1;
      mq.delete();
      checkOutput("arst_valid", 64'(out_valid), 64'd0);
      checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("arst_pc", out_pc, 64'd0);
      #1 rst_n = 1'b1;

      // Random traffic with occasional flushes.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] r;
         r = $urandom;
         applyStimulus(r[1:0] != 2'b00, rand_inst(), {32'h0, $urandom} & 64'hFFFF_FFFC,
                       r[4:2] > 3'd2, r[9:5] == 5'd0, acc);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, acc);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ysyx_220053_alu_issue.md
Name: ysyx_220053_alu_issue

Overview:
- Decode-and-issue stage that sits directly upstream of the EX-stage ALU.
- Takes fetched RV64I instructions over a valid/ready handshake and decodes the integer-ALU subset into the ALU's 4-bit ALUOp encoding, operand selects, register indices and immediate.
- Buffers decoded micro-ops in a 2-entry skid buffer and presents them to EX over a second valid/ready handshake.
- Sustains one instruction per cycle under continuous flow.

Parameters:
- XLEN, 64, datapath width of pc and immediate
- ILEN, 32, instruction width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush; kills all buffered and incoming instructions
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept an instruction this cycle
- in_inst  input  ILEN  raw instruction word
- in_pc  input  XLEN  instruction address
- out_valid  output  1  decoded micro-op valid
- out_ready  input  1  EX accepts the micro-op this cycle
- out_pc  output  XLEN  pc of the issued instruction
- out_aluop  output  4  ALU operation code
- out_rs1  output  5  source register 1 index
- out_rs2  output  5  source register 2 index
- out_rd  output  5  destination register index
- out_imm  output  XLEN  sign-extended immediate
- out_asel  output  1  ALU input A: 0 = rs1, 1 = pc
- out_bsel  output  1  ALU input B: 0 = rs2, 1 = imm
- out_wen  output  1  register write enable
- out_word  output  1  32-bit (W) operation; EX sign-extends the low 32 bits of the result
- out_illegal  output  1  instruction not in the supported subset

Behaviour:
- Reset (rst_n low, asynchronous): buffer empty, out_valid=0, in_ready=1, all payload outputs 0. Reset asserted mid-transfer discards all buffered entries.
- Handshakes:
  - Transfer in on in_valid&in_ready.
  - Transfer out on out_valid&out_ready.
  - Payload outputs are stable while out_valid=1 and out_ready=0.
- Latency: an accepted instruction appears at out_* the next cycle (1-cycle decode, registered outputs).
- Buffer FSM:
  - EMPTY: on accept -> ONE.
  - ONE: accept & !drain -> TWO; drain & !accept -> EMPTY; accept & drain or neither -> ONE.
  - TWO: drain -> ONE (the skid entry moves to the head); no accept is possible in TWO.
- in_ready is a register: 1 in EMPTY/ONE, 0 in TWO. It never depends combinationally on out_ready.
- Entries issue in strict FIFO order; there is no reordering or duplication.
- flush: at the next edge the FSM enters EMPTY, out_valid=0 and in_ready=1. An instruction presented in the same cycle is dropped. flush has priority over accept and drain.
- ALUOp encoding (fixed, shared with the ALU):
  - 0000 add, 0001 sll, 0010 slt, 0011 sltu
  - 0100 xor, 0101 srl, 0110 or, 0111 and
  - 1000 sub, 1101 sra, 1111 pass-B
- OP-IMM (0010011), bsel=1, I-immediate:
  - funct3 000..111 -> addi 0000, slli 0001, slti 0010, sltiu 0011, xori 0100, srli/srai 0101/1101 (selected by inst[30]), ori 0110, andi 0111.
  - Shift amount is imm[5:0]; inst[31:26] other than 000000/010000 is illegal.
- OP (0110011), bsel=0:
  - funct7 0000000: same mapping as OP-IMM.
  - funct7 0100000: funct3 000 -> sub 1000, funct3 101 -> sra 1101.
  - Any other funct7/funct3 combination is illegal.
- LUI: aluop 1111, bsel=1, imm = sign-extended {inst[31:12],12'b0}.
- AUIPC: aluop 0000, asel=1, bsel=1, same U-immediate as LUI.
- Illegal or unsupported opcode: out_illegal=1, aluop 0000, wen=0, asel=bsel=0, word=0.
- out_wen = legal & (rd != 0).
- rs1/rs2/rd are always the raw fields inst[19:15], inst[24:20], inst[11:7].

Optional Feature:
- Macro: YSYX_220053_RV64W_EN.
- Defined: OP-IMM-32 (0011011) and OP-32 (0111011) decode with out_word=1:
  - addiw/addw 0000, subw 1000, slliw/sllw 0001, srliw/srlw 0101, sraiw/sraw 1101.
  - W-shift immediates require inst[25]=0; otherwise the instruction is illegal.
- Not defined: both opcodes are illegal and out_word is tied to 0.

Test Plan:
- Reset release, then addi x5,x0,-1 (0xFFF00293), out_ready=1 -> next cycle out_valid=1, aluop=0000, imm=0xFFFFFFFFFFFFFFFF, rd=5, bsel=1, wen=1.
- Back-to-back sub, sra, sltu, and, out_ready=1 -> one issue per cycle with aluop 1000, 1101, 0011, 0111 in order; in_ready stays 1.
- out_ready=0 while 3 instructions are offered -> buffer fills to TWO, in_ready=0 after the 2nd accept; release out_ready -> 2 issues in order, 3rd accepted only after in_ready returns to 1, nothing lost or duplicated.
- lui x1,0x80000 -> aluop 1111, imm=0xFFFFFFFF80000000; auipc x2,1 with pc 0x80000000 -> asel=1, imm=0x1000, out_pc=0x80000000.
- Buffer in TWO, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instructions never appear.
- addw x3,x1,x2 (0x002081BB) -> with macro: aluop 0000, word=1, illegal=0; without macro: illegal=1, wen=0; and 0xFFFFFFFF -> illegal=1 in both builds.
